// File: rtl/tile_pingpong_buffer.sv
// Round-robin multi-bank tile buffer: row-major write beats in, DIM-lane beats out,
// read either transposed (column) or straight (row), tiles leave in arrival order.
module tile_pingpong_buffer #(
    parameter int DWIDTH   = 8,
    parameter int DIM      = 4,
    parameter int WR_ELEMS = 4,
    parameter int NBANK    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          wr_acq,
    output logic                          wr_rdy,
    input  logic [WR_ELEMS*DWIDTH-1:0]    wr_data,
    input  logic                          rd_acq,
    input  logic                          rd_mode,
    output logic                          rd_rdy,
    output logic [DIM*DWIDTH-1:0]         rd_data,
    output logic                          rd_last,
    output logic [$clog2(NBANK+1)-1:0]    occ
);
    localparam int NBEATS = DIM * DIM / WR_ELEMS;
    localparam int AW     = $clog2(DIM * DIM);
    localparam int BW     = $clog2(NBANK);
    localparam int WIW    = $clog2(NBEATS);
    localparam int RIW    = $clog2(DIM);
    localparam int OW     = $clog2(NBANK + 1);

    logic [BW-1:0]  wr_bank_reg, wr_bank_next;
    logic [BW-1:0]  rd_bank_reg, rd_bank_next;
    logic [WIW-1:0] wr_idx_reg, wr_idx_next;
    logic [RIW-1:0] rd_idx_reg, rd_idx_next;
    logic [OW-1:0]  occ_reg, occ_next;
    logic           tile_mode_reg, tile_mode_next;

    logic           wr_fire, rd_fire, wr_tile_done, rd_tile_done, rd_mode_eff;

    // Tile storage, not reset; read combinationally so data is show-ahead.
    logic [DWIDTH-1:0] mem [NBANK][DIM*DIM];

    function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
        return (b == BW'(NBANK - 1)) ? '0 : b + BW'(1);
    endfunction

    assign wr_rdy       = (occ_reg < OW'(NBANK));
    assign rd_rdy       = (occ_reg != '0);
    assign wr_fire      = wr_acq & wr_rdy;
    assign rd_fire      = rd_acq & rd_rdy;
    assign wr_tile_done = wr_fire & (wr_idx_reg == WIW'(NBEATS - 1));
    assign rd_tile_done = rd_fire & (rd_idx_reg == RIW'(DIM - 1));
    assign rd_last      = rd_rdy & (rd_idx_reg == RIW'(DIM - 1));
    assign rd_mode_eff  = (rd_idx_reg == '0) ? rd_mode : tile_mode_reg;
    assign occ          = occ_reg;

    always_comb begin
        wr_bank_next   = wr_bank_reg;
        rd_bank_next   = rd_bank_reg;
        wr_idx_next    = wr_idx_reg;
        rd_idx_next    = rd_idx_reg;
        occ_next       = occ_reg;
        tile_mode_next = tile_mode_reg;
        if (flush) begin
            // A flush drops any same-cycle fire and discards partial tiles.
            wr_bank_next = '0;
            rd_bank_next = '0;
            wr_idx_next  = '0;
            rd_idx_next  = '0;
            occ_next     = '0;
        end else begin
            if (wr_fire) begin
                wr_idx_next  = wr_tile_done ? '0 : wr_idx_reg + WIW'(1);
                wr_bank_next = wr_tile_done ? bank_inc(wr_bank_reg) : wr_bank_reg;
            end
            if (rd_fire) begin
                rd_idx_next  = rd_tile_done ? '0 : rd_idx_reg + RIW'(1);
                rd_bank_next = rd_tile_done ? bank_inc(rd_bank_reg) : rd_bank_reg;
                if (rd_idx_reg == '0)
                    tile_mode_next = rd_mode;
            end
            case ({wr_tile_done, rd_tile_done})
                2'b10:   occ_next = occ_reg + OW'(1);
                2'b01:   occ_next = occ_reg - OW'(1);
                default: occ_next = occ_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank_reg   <= '0;
            rd_bank_reg   <= '0;
            wr_idx_reg    <= '0;
            rd_idx_reg    <= '0;
            occ_reg       <= '0;
            tile_mode_reg <= 1'b0;
        end else begin
            wr_bank_reg   <= wr_bank_next;
            rd_bank_reg   <= rd_bank_next;
            wr_idx_reg    <= wr_idx_next;
            rd_idx_reg    <= rd_idx_next;
            occ_reg       <= occ_next;
            tile_mode_reg <= tile_mode_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_fire) begin
            for (int j = 0; j < WR_ELEMS; j++)
                mem[wr_bank_reg][AW'(int'(wr_idx_reg) * WR_ELEMS + j)] <= wr_data[j*DWIDTH +: DWIDTH];
        end
    end

    // Lane gi: column mode picks element (gi, rd_idx), row mode picks (rd_idx, gi).
    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
            logic [AW-1:0] col_addr, row_addr;
            assign col_addr = AW'(gi * DIM + int'(rd_idx_reg));
            assign row_addr = AW'(int'(rd_idx_reg) * DIM + gi);
            assign rd_data[gi*DWIDTH +: DWIDTH] = mem[rd_bank_reg][rd_mode_eff ? row_addr : col_addr];
        end
    endgenerate
endmodule

// File: tb/tb_tile_pingpong_buffer.sv
// Scoreboard bench: stimulus queues expected read beats, a negedge monitor checks each read fire.
module tb_tile_pingpong_buffer;
    logic        clk = 1'b0;
    logic        rst_n, flush, wr_acq, rd_acq, rd_mode;
    logic [31:0] wr_data;
    logic        wr_rdy, rd_rdy, rd_last;
    logic [31:0] rd_data;
    logic [1:0]  occ;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    tile_pingpong_buffer #(.DWIDTH(8), .DIM(4), .WR_ELEMS(4), .NBANK(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_acq(wr_acq), .wr_rdy(wr_rdy), .wr_data(wr_data),
        .rd_acq(rd_acq), .rd_mode(rd_mode), .rd_rdy(rd_rdy),
        .rd_data(rd_data), .rd_last(rd_last), .occ(occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else
            $display("ok   %s: 0x%0h", name, act);
    endtask

    // Monitor: every read fire must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && !flush && rd_acq && rd_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_beat: unexpected beat 0x%0h last=%0b, expected none", rd_data, rd_last);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rd_beat", {31'd0, rd_last, rd_data}, {31'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] beat_word(input logic [7:0] base, input int b);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[j*8 +: 8] = base + 8'(4*b + j);
        return w;
    endfunction

    function automatic logic [31:0] exp_beat(input logic [7:0] base, input logic mode, input int k);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = base + 8'(mode ? (k*4 + i) : (i*4 + k));
        return w;
    endfunction

    task automatic wait_wr_rdy();
        int n = 0;
        while (!wr_rdy && n < 100) begin step(); n++; end
        if (!wr_rdy) chk("wr_rdy_timeout", {63'd0, wr_rdy}, 64'd1);
    endtask

    task automatic wait_rd_rdy();
        int n = 0;
        while (!rd_rdy && n < 100) begin step(); n++; end
        if (!rd_rdy) chk("rd_rdy_timeout", {63'd0, rd_rdy}, 64'd1);
    endtask

    task automatic write_tile(input logic [7:0] base);
        for (int b = 0; b < 4; b++) begin
            wait_wr_rdy();
            wr_acq  = 1'b1;
            wr_data = beat_word(base, b);
            step();
        end
        wr_acq = 1'b0;
    endtask

    task automatic read_tile(input logic [7:0] base, input logic mode, input bit toggle);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({(k == 3), exp_beat(base, mode, k)});
            wait_rd_rdy();
            rd_mode = (toggle && (k % 2 == 1)) ? ~mode : mode;
            rd_acq  = 1'b1;
            step();
        end
        rd_acq = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int wb, rb, cyc;
        bit wf, rf;
        rst_n = 1'b0; flush = 1'b0; wr_acq = 1'b0; rd_acq = 1'b0; rd_mode = 1'b0; wr_data = '0;
        do_reset();
        chk("reset_wr_rdy", {63'd0, wr_rdy}, 64'd1);
        chk("reset_rd_rdy", {63'd0, rd_rdy}, 64'd0);
        chk("reset_rd_last", {63'd0, rd_last}, 64'd0);
        chk("reset_occ", {62'd0, occ}, 64'd0);

        // Column read with hand-computed transposed beats.
        write_tile(8'h00);
        exp_q.push_back({1'b0, 32'h0C080400});
        exp_q.push_back({1'b0, 32'h0D090501});
        exp_q.push_back({1'b0, 32'h0E0A0602});
        exp_q.push_back({1'b1, 32'h0F0B0703});
        for (int k = 0; k < 4; k++) begin
            wait_rd_rdy();
            rd_mode = 1'b0; rd_acq = 1'b1;
            step();
        end
        rd_acq = 1'b0;
        chk("col_occ_after", {62'd0, occ}, 64'd0);

        // Row read, rd_mode toggled after beat 0 must not matter.
        write_tile(8'h00);
        exp_q.push_back({1'b0, 32'h03020100});
        exp_q.push_back({1'b0, 32'h07060504});
        exp_q.push_back({1'b0, 32'h0B0A0908});
        exp_q.push_back({1'b1, 32'h0F0E0D0C});
        for (int k = 0; k < 4; k++) begin
            wait_rd_rdy();
            rd_mode = (k % 2 == 0); rd_acq = 1'b1;
            step();
        end
        rd_acq = 1'b0;

        // Full: third tile's first beat is refused.
        write_tile(8'h80);
        write_tile(8'h90);
        chk("full_wr_rdy", {63'd0, wr_rdy}, 64'd0);
        chk("full_occ", {62'd0, occ}, 64'd2);
        wr_acq = 1'b1; wr_data = beat_word(8'hA0, 0);
        step();
        wr_acq = 1'b0;
        chk("full_occ_after_9th", {62'd0, occ}, 64'd2);
        chk("full_wr_rdy_held", {63'd0, wr_rdy}, 64'd0);
        read_tile(8'h80, 1'b1, 1'b0);
        chk("full_wr_rdy_rise", {63'd0, wr_rdy}, 64'd1);
        read_tile(8'h90, 1'b0, 1'b0);
        chk("full_occ_drained", {62'd0, occ}, 64'd0);

        // Concurrency: 4 tiles streamed with both sides requesting every cycle.
        for (int t = 0; t < 4; t++)
            for (int k = 0; k < 4; k++)
                exp_q.push_back({(k == 3), exp_beat(8'h40 + 8'(16*t), 1'b0, k)});
        wb = 0; rb = 0; cyc = 0;
        rd_mode = 1'b0;
        while (rb < 16 && cyc < 100) begin
            wr_acq  = (wb < 16);
            wr_data = beat_word(8'h40 + 8'(16*(wb/4)), wb % 4);
            rd_acq  = 1'b1;
            chk("conc_occ", {62'd0, occ}, 64'(wb/4 - rb/4));
            wf = wr_acq && wr_rdy;
            rf = rd_acq && rd_rdy;
            step();
            if (wf) wb++;
            if (rf) rb++;
            cyc++;
        end
        wr_acq = 1'b0; rd_acq = 1'b0;
        chk("conc_cycles", 64'(cyc), 64'd20);
        chk("conc_occ_end", {62'd0, occ}, 64'd0);

        // Empty: rd_acq held high before any tile exists.
        rd_mode = 1'b0; rd_acq = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), exp_beat(8'hE0, 1'b0, k)});
        for (int c = 0; c < 3; c++) begin
            step();
            chk("empty_rd_rdy", {63'd0, rd_rdy}, 64'd0);
        end
        for (int b = 0; b < 4; b++) begin
            wr_acq = 1'b1; wr_data = beat_word(8'hE0, b);
            chk("empty_rd_rdy_during_write", {63'd0, rd_rdy}, 64'd0);
            step();
        end
        wr_acq = 1'b0;
        chk("empty_rd_rdy_rise", {63'd0, rd_rdy}, 64'd1);
        for (int k = 0; k < 4; k++) step();
        rd_acq = 1'b0;
        chk("empty_occ_end", {62'd0, occ}, 64'd0);

        // Mid-tile flush, then the same sequence with reset.
        for (int pass = 0; pass < 2; pass++) begin
            logic [7:0] pb;
            pb = (pass == 0) ? 8'hB0 : 8'h10;
            write_tile(pb);
            exp_q.push_back({1'b0, exp_beat(pb, 1'b1, 0)});
            rd_mode = 1'b1; rd_acq = 1'b1;
            wr_acq = 1'b1; wr_data = beat_word(8'hC0, 0);
            step();
            rd_acq = 1'b0; wr_data = beat_word(8'hC0, 1);
            step();
            wr_data = beat_word(8'hEE, 0);
            if (pass == 0) flush = 1'b1; else rst_n = 1'b0;
            step();
            flush = 1'b0; rst_n = 1'b1; wr_acq = 1'b0;
            chk(pass == 0 ? "flush_occ" : "rst_occ", {62'd0, occ}, 64'd0);
            chk(pass == 0 ? "flush_rd_rdy" : "rst_rd_rdy", {63'd0, rd_rdy}, 64'd0);
            chk(pass == 0 ? "flush_wr_rdy" : "rst_wr_rdy", {63'd0, wr_rdy}, 64'd1);
            write_tile(pb + 8'h20);
            read_tile(pb + 8'h20, pass == 0, 1'b1);
            chk(pass == 0 ? "flush_occ_end" : "rst_occ_end", {62'd0, occ}, 64'd0);
        end

        step();
        step();
        if (exp_q.size() != 0) chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
